// File: rtl/bcd_arb_defs.sv
// Shared definitions for the BCD converter arbiter: FSM encodings, default width, clog2 helper.
package bcd_arb_defs;

  localparam int unsigned BCDARB_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } arb_state_e;

  // Ceiling log2 usable in constant expressions; returns 0 for v <= 1.
  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping modulo N_REQ.
module rr_arbiter
  import bcd_arb_defs::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned PW = clog2_u(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_c,
  output logic [PW-1:0]    idx_c,
  output logic             found_c
);

  localparam int unsigned SW = PW + 1;

  logic [SW-1:0] pos;

  // pos = (ptr + off) mod N_REQ; the sum never exceeds 2*N_REQ-2 so one subtraction suffices.
  always_comb begin
    gnt_c   = '0;
    idx_c   = '0;
    found_c = 1'b0;
    pos     = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      pos = {1'b0, ptr_i} + SW'(off);
      if (pos >= SW'(N_REQ)) pos = pos - SW'(N_REQ);
      if (!found_c && req_i[pos[PW-1:0]]) begin
        found_c            = 1'b1;
        idx_c              = pos[PW-1:0];
        gnt_c[pos[PW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin sharing of one binary->BCD converter among N_REQ requesters.
// Optional WAIT timeout abort is enabled by defining BCDARB_TIMEOUT_EN.
module bcd_conv_arbiter
  import bcd_arb_defs::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned W       = BCDARB_W_DEFAULT,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               conv_init,
  output logic [W-1:0]       conv_a,
  input  logic [W-1:0]       conv_c,
  input  logic               conv_done
);

  localparam int unsigned PW = clog2_u(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_cfg_check
    $error("bcd_conv_arbiter: N_REQ must be 2..8 and TIMEOUT >= 1");
  end

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     rsp_data_q, rsp_data_d;
  logic [W-1:0]     conv_a_q, conv_a_d;
  logic             busy_q, busy_d;
  logic             conv_init_q, conv_init_d;
  logic [PW-1:0]    ptr_q, ptr_d;

  logic [N_REQ-1:0] pick_gnt_c;
  logic [PW-1:0]    pick_idx_c;
  logic             pick_found_c;
  logic [W-1:0]     pick_a_c;

`ifdef BCDARB_TIMEOUT_EN
  localparam int unsigned CW = clog2_u(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          rsp_err_q, rsp_err_d;
  logic          timeout_hit_c;

  // Counter holds the number of completed WAIT cycles; the TIMEOUT-th one aborts.
  assign timeout_hit_c = (wait_cnt_q == CW'(TIMEOUT - 1));
`endif

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_c   (pick_gnt_c),
    .idx_c   (pick_idx_c),
    .found_c (pick_found_c)
  );

  // Operand of the requester the arbiter would pick this cycle.
  always_comb begin
    pick_a_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_idx_c == PW'(i)) pick_a_c = a_in[i*W +: W];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    conv_a_d    = conv_a_q;
    conv_init_d = 1'b0;
    ptr_d       = ptr_q;
`ifdef BCDARB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    rsp_err_d   = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (pick_found_c) begin
          state_d     = S_LAUNCH;
          gnt_d       = pick_gnt_c;
          conv_a_d    = pick_a_c;
          conv_init_d = 1'b1;
          ptr_d       = (pick_idx_c == PW'(N_REQ - 1)) ? '0 : pick_idx_c + PW'(1);
        end
      end
      S_LAUNCH: begin
        state_d = S_SETTLE;
      end
      // A done still high from the previous conversion is not looked at here.
      S_SETTLE: begin
        state_d = S_WAIT;
`ifdef BCDARB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (conv_done) begin
          state_d     = S_RESP;
          rsp_data_d  = conv_c;
          rsp_valid_d = gnt_q;
        end
`ifdef BCDARB_TIMEOUT_EN
        else if (timeout_hit_c) begin
          state_d     = S_RESP;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = gnt_q;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
`endif
      end
      S_RESP: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      conv_a_q    <= '0;
      busy_q      <= 1'b0;
      conv_init_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      conv_a_q    <= conv_a_d;
      busy_q      <= busy_d;
      conv_init_q <= conv_init_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef BCDARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign conv_init = conv_init_q;
  assign conv_a    = conv_a_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter with a behavioural BCD converter and round-robin reference.
module tb_bcd_conv_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 20;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic           busy;
  logic           conv_init;
  logic [W-1:0]   conv_a;
  logic [W-1:0]   conv_c;
  logic           conv_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Converter model controls
  int           m_lat   = 4;
  bit           m_level = 1'b0;
  bit           m_never = 1'b0;
  int           m_cnt;
  bit           m_drop;
  logic [W-1:0] m_op;

  // Reference state
  int           exp_ptr = 0;
  int           ops [N];

  bcd_conv_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a_in      (a_in),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .conv_init (conv_init),
    .conv_a    (conv_a),
    .conv_c    (conv_c),
    .conv_done (conv_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  // Converter: latches the operand on init, raises done m_lat cycles later (pulse or level).
  always @(posedge clk) begin
    if (reset) begin
      conv_done <= 1'b0;
      conv_c    <= '0;
      m_cnt     <= 0;
      m_drop    <= 1'b0;
      m_op      <= '0;
    end else if (conv_init) begin
      m_op   <= conv_a;
      m_cnt  <= m_lat;
      m_drop <= 1'b1;
      if (!m_level) conv_done <= 1'b0;
    end else begin
      m_drop <= 1'b0;
      if (m_drop || !m_level) conv_done <= 1'b0;
      if (m_cnt == 1 && !m_never) begin
        conv_done <= 1'b1;
        conv_c    <= to_bcd(int'(m_op));
      end
      if (m_cnt > 0) m_cnt <= m_cnt - 1;
    end
  end

  task automatic set_op(input int i, input int v);
    ops[i] = v;
    a_in[i*W +: W] = W'(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b0;
    exp_ptr = 0;
  endtask

  // Waits (bounded) for the next response pulse; samples at negedge.
  task automatic wait_resp(input int budget, output bit to, output int idx, output logic [W-1:0] data,
                           output logic err, output logic [N-1:0] gnt_at, output int oh_bad,
                           output int rsp_cyc, output int last_done_cyc);
    to = 1'b1; idx = -1; data = '0; err = 1'b0; gnt_at = '0; oh_bad = 0;
    rsp_cyc = -1; last_done_cyc = -100;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!$onehot0(gnt)) oh_bad++;
      if (rsp_valid != '0) begin
        to      = 1'b0;
        idx     = $onehot(rsp_valid) ? idx_of(rsp_valid) : -2;
        data    = rsp_data;
        err     = rsp_err;
        gnt_at  = gnt;
        rsp_cyc = cyc;
        return;
      end
      if (conv_done) last_done_cyc = cyc;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; a_in = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({gnt, rsp_valid, rsp_data, rsp_err, busy, conv_init, conv_a} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs gnt=%b rsp_valid=%b rsp_data=%h err=%b busy=%b init=%b conv_a=%h, all must be 0",
               gnt, rsp_valid, rsp_data, rsp_err, busy, conv_init, conv_a);
    end
    reset = 1'b0;
    exp_ptr = 0;
  endtask

  task automatic test_single();
    bit to; int idx, bad, rc, dc, extra; logic [W-1:0] d; logic e; logic [N-1:0] g;
    do_reset();
    m_level = 1'b0; m_never = 1'b0; m_lat = 10;
    set_op(0, 255);
    req = 4'b0001;
    @(negedge clk);
    n_tests++;
    if (conv_init !== 1'b1 || gnt !== 4'b0001 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_launch init=%b gnt=%b busy=%b, need 1/0001/1", conv_init, gnt, busy);
    end
    @(negedge clk);
    n_tests++;
    if (conv_init !== 1'b0) begin
      n_fail++;
      $display("FAIL single_init_pulse conv_init=%b in second cycle, need 0", conv_init);
    end
    wait_resp(100, to, idx, d, e, g, bad, rc, dc);
    n_tests++;
    if (to || idx != 0 || d !== 16'h0255 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL single_resp timeout=%0d idx=%0d data=%h err=%b, need 0/0/0255/0", to, idx, d, e);
    end
    n_tests++;
    if (rc != dc + 1) begin
      n_fail++;
      $display("FAIL single_latency rsp cycle=%0d last done cycle=%0d, need rsp one cycle after done", rc, dc);
    end
    req = '0;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid != '0) extra++;
    end
    n_tests++;
    if (extra != 0 || busy !== 1'b0 || gnt !== '0) begin
      n_fail++;
      $display("FAIL single_idle extra_pulses=%0d busy=%b gnt=%b, need 0/0/0", extra, busy, gnt);
    end
  endtask

  task automatic test_round_robin();
    bit to; int idx, bad, rc, dc, exp; logic [W-1:0] d; logic e; logic [N-1:0] g, oh;
    do_reset();
    m_level = 1'b0; m_never = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, int'($urandom_range(1, 9999)));
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      m_lat = int'($urandom_range(1, 8));
      exp = model_pick(req, exp_ptr);
      exp_ptr = (exp + 1) % N;
      oh = '0; oh[exp] = 1'b1;
      wait_resp(200, to, idx, d, e, g, bad, rc, dc);
      n_tests++;
      if (to || idx != exp || g !== oh || bad != 0) begin
        n_fail++;
        $display("FAIL rr_grant t=%0d timeout=%0d idx=%0d gnt=%b onehot_viol=%0d, need idx %0d gnt %b",
                 t, to, idx, g, bad, exp, oh);
      end
      n_tests++;
      if (d !== to_bcd(ops[exp])) begin
        n_fail++;
        $display("FAIL rr_data t=%0d data=%h, need %h", t, d, to_bcd(ops[exp]));
      end
    end
    req = '0;
  endtask

  task automatic test_stale_done();
    bit to; int idx, bad, rc, dc, x, y; logic [W-1:0] d; logic e; logic [N-1:0] g;
    do_reset();
    m_level = 1'b1; m_never = 1'b0; m_lat = 3;
    x = int'($urandom_range(1, 4999));
    y = x + 1 + int'($urandom_range(0, 4000));
    set_op(1, x);
    req = 4'b0010;
    wait_resp(100, to, idx, d, e, g, bad, rc, dc);
    n_tests++;
    if (to || idx != 1 || d !== to_bcd(x)) begin
      n_fail++;
      $display("FAIL stale_first timeout=%0d idx=%0d data=%h, need idx 1 data %h", to, idx, d, to_bcd(x));
    end
    req = '0;
    repeat (3) @(negedge clk);
    set_op(2, y);
    m_lat = 6;
    req = 4'b0100;
    wait_resp(100, to, idx, d, e, g, bad, rc, dc);
    n_tests++;
    if (to || idx != 2 || d !== to_bcd(y)) begin
      n_fail++;
      $display("FAIL stale_ignored timeout=%0d idx=%0d data=%h, need idx 2 data %h", to, idx, d, to_bcd(y));
    end
    req = '0;
    m_level = 1'b0;
  endtask

  task automatic test_drop_req();
    bit to; int idx, bad, rc, dc; logic [W-1:0] d; logic e; logic [N-1:0] g;
    do_reset();
    m_level = 1'b0; m_never = 1'b0; m_lat = 8;
    set_op(2, int'($urandom_range(1, 9999)));
    set_op(3, int'($urandom_range(1, 9999)));
    req = 4'b1100;
    @(negedge clk);
    n_tests++;
    if (gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL drop_grant gnt=%b, need 0100", gnt);
    end
    repeat (2) @(negedge clk);
    req[2] = 1'b0;
    wait_resp(100, to, idx, d, e, g, bad, rc, dc);
    n_tests++;
    if (to || idx != 2 || d !== to_bcd(ops[2])) begin
      n_fail++;
      $display("FAIL drop_resp timeout=%0d idx=%0d data=%h, need idx 2 data %h", to, idx, d, to_bcd(ops[2]));
    end
    wait_resp(100, to, idx, d, e, g, bad, rc, dc);
    n_tests++;
    if (to || idx != 3 || d !== to_bcd(ops[3])) begin
      n_fail++;
      $display("FAIL drop_next timeout=%0d idx=%0d data=%h, need idx 3 data %h", to, idx, d, to_bcd(ops[3]));
    end
    req = '0;
    exp_ptr = 0;
  endtask

  task automatic test_reset_in_wait();
    bit to; int idx, bad, rc, dc, pulses; logic [W-1:0] d; logic e; logic [N-1:0] g;
    m_level = 1'b0; m_never = 1'b0; m_lat = 30;
    set_op(0, int'($urandom_range(1, 9999)));
    req = 4'b0001;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    n_tests++;
    if ({gnt, rsp_valid, rsp_data, rsp_err, busy, conv_init, conv_a} !== '0) begin
      n_fail++;
      $display("FAIL wait_reset_outputs gnt=%b rsp_valid=%b rsp_data=%h err=%b busy=%b init=%b conv_a=%h, all must be 0",
               gnt, rsp_valid, rsp_data, rsp_err, busy, conv_init, conv_a);
    end
    reset = 1'b0;
    exp_ptr = 0;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid != '0 || busy) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL wait_reset_quiet active_cycles=%0d after reset, need 0", pulses);
    end
    m_lat = 5;
    set_op(0, int'($urandom_range(1, 9999)));
    set_op(1, int'($urandom_range(1, 9999)));
    req = 4'b0011;
    wait_resp(100, to, idx, d, e, g, bad, rc, dc);
    n_tests++;
    if (to || idx != 0 || d !== to_bcd(ops[0])) begin
      n_fail++;
      $display("FAIL wait_reset_ptr timeout=%0d idx=%0d data=%h, need idx 0 data %h", to, idx, d, to_bcd(ops[0]));
    end
    req[0] = 1'b0;
    wait_resp(100, to, idx, d, e, g, bad, rc, dc);
    n_tests++;
    if (to || idx != 1 || d !== to_bcd(ops[1])) begin
      n_fail++;
      $display("FAIL wait_reset_req1 timeout=%0d idx=%0d data=%h, need idx 1 data %h", to, idx, d, to_bcd(ops[1]));
    end
    req = '0;
    exp_ptr = 2;
  endtask

  task automatic test_timeout();
    bit to; int idx, bad, rc, dc, c_init; logic [W-1:0] d; logic e; logic [N-1:0] g;
    m_level = 1'b0; m_never = 1'b1; m_lat = 3;
    set_op(0, int'($urandom_range(1, 9999)));
    req = 4'b0001;
    @(negedge clk);
    c_init = cyc;
`ifdef BCDARB_TIMEOUT_EN
    wait_resp(100, to, idx, d, e, g, bad, rc, dc);
    n_tests++;
    if (to || idx != 0 || e !== 1'b1 || d !== '0) begin
      n_fail++;
      $display("FAIL timeout_abort timeout=%0d idx=%0d err=%b data=%h, need 0/0/1/0000", to, idx, e, d);
    end
    n_tests++;
    if (rc - c_init != TO + 2) begin
      n_fail++;
      $display("FAIL timeout_cycles resp %0d cycles after launch, need %0d", rc - c_init, TO + 2);
    end
    req = '0;
    m_never = 1'b0;
    @(negedge clk);
    set_op(1, int'($urandom_range(1, 9999)));
    req = 4'b0010;
    wait_resp(100, to, idx, d, e, g, bad, rc, dc);
    n_tests++;
    if (to || idx != 1 || e !== 1'b0 || d !== to_bcd(ops[1])) begin
      n_fail++;
      $display("FAIL timeout_recover timeout=%0d idx=%0d err=%b data=%h, need idx 1 err 0 data %h",
               to, idx, e, d, to_bcd(ops[1]));
    end
    req = '0;
`else
    wait_resp(60, to, idx, d, e, g, bad, rc, dc);
    n_tests++;
    if (!to || busy !== 1'b1 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_forever got_resp=%0d busy=%b err=%b launch=%0d, need no response, busy 1, err 0",
               !to, busy, rsp_err, c_init);
    end
    m_never = 1'b0;
    do_reset();
`endif
  endtask

  task automatic test_random();
    bit to; int idx, bad, rc, dc, exp; logic [W-1:0] d; logic e; logic [N-1:0] g, r;
    do_reset();
    m_never = 1'b0;
    r = '0;
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!r[i] && $urandom_range(0, 1) == 1) begin
          set_op(i, int'($urandom_range(0, 9999)));
          r[i] = 1'b1;
        end
      end
      if (r == '0) begin
        set_op(0, int'($urandom_range(0, 9999)));
        r[0] = 1'b1;
      end
      req = r;
      m_lat = int'($urandom_range(1, 12));
      m_level = 1'($urandom_range(0, 1));
      exp = model_pick(r, exp_ptr);
      exp_ptr = (exp + 1) % N;
      wait_resp(200, to, idx, d, e, g, bad, rc, dc);
      n_tests++;
      if (to || idx != exp || bad != 0 || d !== to_bcd(ops[exp]) || e !== 1'b0) begin
        n_fail++;
        $display("FAIL random t=%0d req=%b timeout=%0d idx=%0d data=%h err=%b onehot_viol=%0d, need idx %0d data %h err 0",
                 t, r, to, idx, d, e, bad, exp, to_bcd(ops[exp]));
      end
      r[exp] = 1'b0;
    end
    req = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    a_in  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_stale_done();
    test_drop_req();
    test_reset_in_wait();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
